run_detect_sched: RTL and testbench

- Shared consecutive-ones run detector for N_CH serial bit channels.
- A single update engine is time-shared by a round-robin arbiter. At most one channel bit is consumed per cycle.
- Per-channel run-length contexts are held in a register file. Each channel gets a Moore-style detect level and a crossing event.
- A control FSM sequences enable, threshold reconfiguration and a context-clear sweep.

---
 rtl/run_detect_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/run_detect_sched.sv | 142 ++++++++++++++
 tb/tb_run_detect_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_detect_pkg.sv
// Shared types and helpers for the time-shared consecutive-ones run detector.
package run_detect_pkg;

  localparam int EV_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CLR
  } state_e;

  // Increment that sticks at max_v instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? max_v : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_CH-1:0]  gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  int               s;
  logic [PTR_W-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    s     = 0;
    j     = '0;
    for (int k = 0; k < N_CH; k++) begin
      s = int'(ptr_i) + k;
      if (s >= N_CH) s = s - N_CH;
      j = PTR_W'(s);
      if (!any_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = j;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_detect_sched.sv
// Round-robin shared run-length detector over N_CH serial channels.
// Define RDS_STATS_EN to build the saturating detection-event counter on ev_count.
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 4,
  parameter int THRESH_RST = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_CH-1:0]         req_valid,
  input  logic [N_CH-1:0]         req_bit,
  output logic [N_CH-1:0]         req_ready,
  input  logic                    cfg_we,
  input  logic [CNT_W-1:0]        cfg_thresh,
  output logic [N_CH-1:0]         det,
  output logic                    ev_valid,
  output logic [$clog2(N_CH)-1:0] ev_ch,
  output logic                    clr_busy,
  output logic [EV_COUNT_W-1:0]   ev_count
);

  localparam int          CH_W    = $clog2(N_CH);
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  state_e           state_q;
  logic [CNT_W-1:0] thresh_q;
  logic [CH_W-1:0]  clr_idx_q;
  logic             clr_busy_q;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]  det_q;
  logic [CH_W-1:0]  rr_ptr_q;
  logic             ev_valid_q;
  logic [CH_W-1:0]  ev_ch_q;

  logic [N_CH-1:0]  gnt;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             arb_en;
  logic             xfer;
  logic [CH_W-1:0]  rr_ptr_d;
  logic [CNT_W-1:0] cnt_d;
  logic             det_d;

  // A config write steals the cycle, so no bit is consumed while thresh moves.
  assign arb_en = (state_q == RUN) && en && !cfg_we;

  rr_arbiter #(.N_CH(N_CH), .PTR_W(CH_W)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready = arb_en ? gnt : '0;
  assign xfer      = arb_en && gnt_any;
  assign rr_ptr_d  = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

  always_comb begin
    cnt_d = '0;
    if (req_bit[gnt_idx]) cnt_d = CNT_W'(sat_inc(32'(cnt_q[gnt_idx]), CNT_MAX));
    det_d = (cnt_d >= thresh_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      thresh_q   <= CNT_W'(THRESH_RST);
      clr_idx_q  <= '0;
      clr_busy_q <= 1'b0;
    end else if (cfg_we) begin
      thresh_q   <= (cfg_thresh == '0) ? CNT_W'(1) : cfg_thresh;
      clr_idx_q  <= '0;
      state_q    <= CLR;
      clr_busy_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (en) state_q <= RUN;
        RUN:  if (!en) state_q <= IDLE;
        CLR: begin
          if (clr_idx_q == CH_W'(N_CH - 1)) begin
            state_q    <= en ? RUN : IDLE;
            clr_busy_q <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + CH_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Context update: one granted bit per cycle, or one swept slot during CLR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      det_q      <= '0;
      rr_ptr_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
    end else begin
      ev_valid_q <= 1'b0;
      if (xfer) begin
        cnt_q[gnt_idx] <= cnt_d;
        det_q[gnt_idx] <= det_d;
        rr_ptr_q       <= rr_ptr_d;
        ev_valid_q     <= det_d & ~det_q[gnt_idx];
        ev_ch_q        <= gnt_idx;
      end else if ((state_q == CLR) && !cfg_we) begin
        cnt_q[clr_idx_q] <= '0;
        det_q[clr_idx_q] <= 1'b0;
      end
    end
  end

  assign det      = det_q;
  assign ev_valid = ev_valid_q;
  assign ev_ch    = ev_ch_q;
  assign clr_busy = clr_busy_q;

`ifdef RDS_STATS_EN
  logic [EV_COUNT_W-1:0] ev_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_count_q <= '0;
    end else if (cfg_we) begin
      ev_count_q <= '0;
    end else if (ev_valid_q) begin
      ev_count_q <= EV_COUNT_W'(sat_inc(32'(ev_count_q), (2 ** EV_COUNT_W) - 1));
    end
  end

  assign ev_count = ev_count_q;
`else
  assign ev_count = '0;
`endif

endmodule

// File: tb/tb_run_detect_sched.sv
// Bench for run_detect_sched: directed vector table, corner sequences, and random traffic vs. a reference model.
module tb_run_detect_sched;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;
`ifdef RDS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [3:0]  req_bit;
  logic [3:0]  req_ready;
  logic        cfg_we;
  logic [3:0]  cfg_thresh;
  logic [3:0]  det;
  logic        ev_valid;
  logic [1:0]  ev_ch;
  logic        clr_busy;
  logic [15:0] ev_count;

  always #5 clk = ~clk;

  run_detect_sched #(.N_CH(N_CH), .CNT_W(CNT_W), .THRESH_RST(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_bit    (req_bit),
    .req_ready  (req_ready),
    .cfg_we     (cfg_we),
    .cfg_thresh (cfg_thresh),
    .det        (det),
    .ev_valid   (ev_valid),
    .ev_ch      (ev_ch),
    .clr_busy   (clr_busy),
    .ev_count   (ev_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0=idle, 1=run, 2=clearing.
  int m_state, m_idx, m_thresh, m_ptr, m_evc, m_evcount;
  int m_cnt [4];
  bit m_det [4];
  bit m_evv;

  task automatic m_reset();
    m_state = 0; m_idx = 0; m_thresh = 2; m_ptr = 0;
    m_evc = 0; m_evcount = 0; m_evv = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c] = 0;
      m_det[c] = 1'b0;
    end
  endtask

  function automatic int m_grant();
    int c;
    if (m_state == 1 && en && !cfg_we) begin
      for (int k = 0; k < N_CH; k++) begin
        c = (m_ptr + k) % N_CH;
        if (((int'(req_valid) >> c) & 1) != 0) return c;
      end
    end
    return -1;
  endfunction

  function automatic int m_det_vec();
    int v = 0;
    for (int c = 0; c < N_CH; c++) if (m_det[c]) v = v | (1 << c);
    return v;
  endfunction

  task automatic m_step();
    int g, nc;
    bit nd, nev;
    g   = m_grant();
    nev = 1'b0;
    if (STATS) begin
      if (cfg_we) m_evcount = 0;
      else if (m_evv && m_evcount < 65535) m_evcount++;
    end
    if (g >= 0) begin
      if (((int'(req_bit) >> g) & 1) != 0) nc = (m_cnt[g] + 1 > 15) ? 15 : m_cnt[g] + 1;
      else nc = 0;
      nd  = (nc >= m_thresh);
      nev = nd && !m_det[g];
      if (nev) m_evc = g;
      m_cnt[g] = nc;
      m_det[g] = nd;
      m_ptr    = (g + 1) % N_CH;
    end
    m_evv = nev;
    if (cfg_we) begin
      m_thresh = (cfg_thresh == 4'd0) ? 1 : int'(cfg_thresh);
      m_state  = 2;
      m_idx    = 0;
    end else if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 1) begin
      if (!en) m_state = 0;
    end else begin
      m_cnt[m_idx] = 0;
      m_det[m_idx] = 1'b0;
      if (m_idx == N_CH - 1) m_state = en ? 1 : 0;
      else m_idx++;
    end
  endtask

  int s_ready, s_det, s_evv, s_evc, s_busy, s_evcount;

  // One clock: drive, sample at negedge (optionally vs. model), advance model at posedge.
  task automatic cycle(input bit e, input bit c, input int th, input int va, input int bi,
                       input bit use_model, input string tag);
    int g;
    en = e; cfg_we = c; cfg_thresh = 4'(th); req_valid = 4'(va); req_bit = 4'(bi);
    @(negedge clk);
    s_ready = int'(req_ready); s_det = int'(det); s_evv = int'(ev_valid);
    s_evc = int'(ev_ch); s_busy = int'(clr_busy); s_evcount = int'(ev_count);
    if (use_model) begin
      g = m_grant();
      chk({tag, "_ready"}, s_ready, (g < 0) ? 0 : (1 << g));
      chk({tag, "_det"}, s_det, m_det_vec());
      chk({tag, "_evv"}, s_evv, int'(m_evv));
      if (m_evv) chk({tag, "_evch"}, s_evc, m_evc);
      chk({tag, "_busy"}, s_busy, (m_state == 2) ? 1 : 0);
      chk({tag, "_evcount"}, s_evcount, m_evcount);
    end
    @(posedge clk);
    m_step();
    #1;
  endtask

  typedef struct packed {
    logic       en;
    logic       cfg;
    logic [3:0] th;
    logic [3:0] val;
    logic [3:0] bits;
    logic [3:0] ready;
    logic [3:0] det;
    logic       evv;
    logic [1:0] evc;
    logic       busy;
  } vec_t;

  vec_t tbl [26];
  int   nb;
  int   bi;

  initial begin
    rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_thresh = '0;
    req_valid = 4'hF; req_bit = 4'hF;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_det", int'(det), 0);
    chk("rst_evv", int'(ev_valid), 0);
    chk("rst_evch", int'(ev_ch), 0);
    chk("rst_busy", int'(clr_busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_evcount", int'(ev_count), 0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; req_valid = '0; req_bit = '0;
    @(posedge clk);
    #1;

    //         en    cfg   th    val      bits     ready    det      evv   evc   busy
    tbl[0]  = '{1'b1, 1'b0, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'd0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'd0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4'd0, 4'b1111, 4'b0000, 4'b0010, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'd0, 4'b1111, 4'b0000, 4'b0100, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'd0, 4'b1111, 4'b0000, 4'b1000, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'd0, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4'd0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'd0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'd0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4'd0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 4'd0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 4'd3, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 4'd0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 4'd0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[18] = '{1'b1, 1'b0, 4'd0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 4'd0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 4'd0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 4'd0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 4'd0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[23] = '{1'b1, 1'b0, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 4'd0, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 4'd0, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0};

    for (int i = 0; i < 26; i++) begin
      cycle(tbl[i].en, tbl[i].cfg, int'(tbl[i].th), int'(tbl[i].val), int'(tbl[i].bits), 1'b0, "tbl");
      chk($sformatf("tbl%0d_ready", i), s_ready, int'(tbl[i].ready));
      chk($sformatf("tbl%0d_det", i), s_det, int'(tbl[i].det));
      chk($sformatf("tbl%0d_evv", i), s_evv, int'(tbl[i].evv));
      if (tbl[i].evv) chk($sformatf("tbl%0d_evch", i), s_evc, int'(tbl[i].evc));
      chk($sformatf("tbl%0d_busy", i), s_busy, int'(tbl[i].busy));
    end
    chk("tbl_evcount", s_evcount, STATS ? 1 : 0);

    // Zero threshold is promoted to 1: a single 1 detects.
    cycle(1'b1, 1'b1, 0, 0, 0, 1'b1, "thr0");
    repeat (4) cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "thr0clr");
    cycle(1'b1, 1'b0, 0, 8, 8, 1'b1, "thr0x");
    cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "thr0chk");
    chk("thr0_det3", (s_det >> 3) & 1, 1);
    chk("thr0_ev", s_evv, 1);
    chk("thr0_evch", s_evc, 3);

    // Second write mid-sweep restarts it.
    cycle(1'b1, 1'b1, 2, 0, 0, 1'b1, "rs1");
    cycle(1'b1, 1'b0, 0, 15, 15, 1'b1, "rs");
    cycle(1'b1, 1'b0, 0, 15, 15, 1'b1, "rs");
    cycle(1'b1, 1'b1, 2, 15, 15, 1'b1, "rs2");
    nb = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "rsw");
      if (s_busy != 0) nb++;
    end
    chk("restart_len", nb, N_CH);

    // Sixteen 1,1,0 runs on ch0, then a config write.
    cycle(1'b1, 1'b1, 2, 0, 0, 1'b1, "st");
    repeat (4) cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "stclr");
    for (int r = 0; r < 16; r++) begin
      cycle(1'b1, 1'b0, 0, 1, 1, 1'b1, "strun");
      cycle(1'b1, 1'b0, 0, 1, 1, 1'b1, "strun");
      cycle(1'b1, 1'b0, 0, 1, 0, 1'b1, "strun");
    end
    repeat (2) cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "stidle");
    chk("stats_cnt", s_evcount, STATS ? 16 : 0);
    cycle(1'b1, 1'b1, 2, 0, 0, 1'b1, "stcfg");
    cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "stcfg1");
    chk("stats_clr", s_evcount, 0);
    repeat (3) cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "stclr2");

    // Reset in the middle of a sweep.
    cycle(1'b1, 1'b0, 0, 2, 2, 1'b1, "mr");
    cycle(1'b1, 1'b0, 0, 2, 2, 1'b1, "mr");
    cycle(1'b1, 1'b1, 5, 0, 0, 1'b1, "mrcfg");
    rst = 1'b1;
    #2;
    chk("mr_busy", int'(clr_busy), 0);
    chk("mr_det", int'(det), 0);
    chk("mr_evv", int'(ev_valid), 0);
    chk("mr_evcount", int'(ev_count), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; cfg_we = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "mrrun");
    cycle(1'b1, 1'b0, 0, 1, 1, 1'b1, "mrrun");
    cycle(1'b1, 1'b0, 0, 1, 1, 1'b1, "mrrun");
    cycle(1'b1, 1'b0, 0, 0, 0, 1'b1, "mrrun");
    chk("mr_thresh_rst", s_det & 1, 1);

    // Random traffic against the model.
    for (int t = 0; t < 400; t++) begin
      bi = 0;
      for (int c = 0; c < N_CH; c++) if ($urandom_range(7, 0) != 0) bi = bi | (1 << c);
      cycle(($urandom % 16) != 0, ($urandom % 32) == 0, int'($urandom % 5),
            int'($urandom % 16), bi, 1'b1, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
